// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and the data RAM.
// The slave view belongs to the arbiter; the master view to the requesters and RAM.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req0;
  logic              req1;
  logic              rw0;
  logic              rw1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              ack0;
  logic              ack1;
  logic [DATA_W-1:0] rdata;
  logic              err;
  logic              busy;
  logic              mem_en;
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req0, req1, rw0, rw1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output ack0, ack1, rdata, err, busy, mem_en, mem_rw, mem_addr, mem_wdata
  );

  modport master (
    output req0, req1, rw0, rw1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  ack0, ack1, rdata, err, busy, mem_en, mem_rw, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data RAM between the CPU data port (0)
// and the debug/loader port (1); inserts read wait states and rejects out-of-range accesses.
module dmem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH_BYTES = 1024,
  parameter int MEM_LAT     = 1
) (
  input logic           clk,
  input logic           rst_n,
  dmem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam int              CNT_W     = 3;
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH_BYTES);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

  state_t              state;
  state_t              state_nxt;
  logic                owner;
  logic                last;
  logic                rw_q;
  logic                err_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [CNT_W-1:0]    cnt;
  logic                grant;
  logic                grant_id;
  logic                in_range;

  // Extra top bit keeps the compare exact even when DEPTH_BYTES exceeds the address space.
  assign in_range = {1'b0, addr_q} < DEPTH_LIM;

  always_comb begin
    state_nxt   = state;
    grant       = 1'b0;
    grant_id    = 1'b0;
    bus.mem_en  = 1'b0;
    bus.ack0    = 1'b0;
    bus.ack1    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          grant     = 1'b1;
          // On a tie the requester that was not served last wins.
          grant_id  = bus.req1 && (!bus.req0 || !last);
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        bus.mem_en = in_range;
        state_nxt  = (in_range && !rw_q) ? WAIT : RESP;
      end
      WAIT: begin
        if (cnt == '0) state_nxt = RESP;
      end
      RESP: begin
        bus.ack0  = !owner;
        bus.ack1  = owner;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Outputs must read as zero right after reset, so the latched fields are reset too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner   <= 1'b0;
      last    <= 1'b1;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      cnt     <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            owner   <= grant_id;
            last    <= grant_id;
            rw_q    <= grant_id ? bus.rw1    : bus.rw0;
            addr_q  <= grant_id ? bus.addr1  : bus.addr0;
            wdata_q <= grant_id ? bus.wdata1 : bus.wdata0;
            err_q   <= 1'b0;
          end
        end
        ISSUE: begin
          if (!in_range) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
          end else if (!rw_q) begin
            cnt <= CNT_INIT;
          end
        end
        WAIT: begin
          if (cnt != '0) cnt     <= cnt - CNT_W'(1);
          else           rdata_q <= bus.mem_rdata;
        end
        default: ;
      endcase
    end
  end

  assign bus.rdata     = rdata_q;
  assign bus.err       = err_q && (state == RESP);
  assign bus.busy      = (state != IDLE);
  assign bus.mem_rw    = rw_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
endmodule
